game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Central sequencer for the shooter game datapath. It generates the movement tick and runs the game-state FSM (IDLE/PLAY/WIN/LOSE). It schedules the alternating enemy volleys and arbitrates player shots onto free player-bullet slots with a cooldown. The bullet generation/movement block consumes its pulses and slot index and performs no timing decisions of its own.

## Interface
- TICK_DIV, 416667, clocks per movement tick (60 Hz at 25 MHz)
- PHASE_LEN, 128, ticks per phase; a volley fires at the end of each phase
- COOLDOWN, 11, ticks between player shots
- MAX_ENEMY, 15, enemy count
- MAX_PLAYER_BULLET, 16, player bullet slots (power of two)

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  asynchronous, active-low reset
- i_Start  in  1  start/restart button (level)
- i_fPlayerShoot  in  1  fire button (level)
- i_EnemyAlive  in  MAX_ENEMY  enemy alive bitmap
- i_PlayerAlive  in  1  player alive
- i_PlayerSlotFree  in  MAX_PLAYER_BULLET  free player-bullet slots bitmap
- o_State  out  2  0=IDLE, 1=PLAY, 2=WIN, 3=LOSE
- o_Tick  out  1  one-cycle movement pulse
- o_Phase  out  2  phase number, wraps 3→0
- o_EnemyFireA  out  1  volley pulse, bullet slots 0..MAX_ENEMY-1
- o_EnemyFireB  out  1  volley pulse, bullet slots MAX_ENEMY..2*MAX_ENEMY-1
- o_PlayerFire  out  1  one-cycle player shot pulse
- o_PlayerSlot  out  log2(MAX_PLAYER_BULLET)  slot for this shot; valid only with o_PlayerFire

## Operation
- **Reset values.** Every output is 0 (o_State=IDLE). The tick counter, phase count, cooldown, pending request, round-robin pointer and volley flag are also 0.
- **Start edge.** The FSM acts on the rising edge of i_Start, registered.
  - IDLE→PLAY on a start edge.
  - WIN→IDLE and LOSE→IDLE on a start edge.
- **Leaving PLAY.**
  - PLAY→LOSE when i_PlayerAlive=0.
  - PLAY→WIN when i_EnemyAlive==0.
  - If both hold in the same cycle, LOSE wins.
- **Entering PLAY.** Clears the tick counter, phase count, o_Phase, cooldown, pending request, pointer and volley flag.
- **Tick divider.** Runs only in PLAY. It counts 0..TICK_DIV-1, and o_Tick=1 in the cycle the count wraps.
- **Phase count.** 7-bit, incremented on o_Tick. On the tick where count==PHASE_LEN-1:
  - count resets to 0;
  - o_Phase increments;
  - the volley flag toggles;
  - o_EnemyFireA (flag was 0) or o_EnemyFireB (flag was 1) pulses.
  - The first volley after PLAY is therefore A.
  - No volley pulse is issued if i_EnemyAlive==0; the flag toggles regardless.
- **Player request.** A rising edge of i_fPlayerShoot sets a sticky pending bit. One press yields at most one shot.
- **Player shot.** Issued on o_Tick when all of these hold: pending, cooldown==0, and |i_PlayerSlotFree. The shot:
  - asserts o_PlayerFire;
  - sets o_PlayerSlot to the first free slot searching upward from the pointer, with wrap;
  - sets pointer = slot+1 (mod MAX_PLAYER_BULLET);
  - clears pending;
  - loads cooldown=COOLDOWN.
- **No free slot.** The request stays pending and is retried on each later tick.
- **Cooldown.** Decrements by 1 on each o_Tick while nonzero; it never underflows.
- **Outside PLAY.** o_Tick, both fire pulses and o_PlayerFire are 0, and button edges are ignored (pending is not set).

## Timing
- All outputs are registered.
- The fire pulses are asserted in the same cycle as the o_Tick that triggers them.
- Input sampling to state change takes 1 cycle. Example: i_PlayerAlive falls in cycle n → o_State=LOSE in cycle n+1, with no pulses in n+1.
- A fire-button edge seen in cycle n can be served by a tick in cycle n+1 or later.
- i_Rst is asynchronous and may assert mid-game: every register returns to its reset value immediately.
- An i_Start edge while already in PLAY is ignored.

## Configuration
- GAME_AUTOFIRE_EN defined: while i_fPlayerShoot is held, pending is re-set every tick, so fire repeats every COOLDOWN+1 ticks when slots are free.
- GAME_AUTOFIRE_EN undefined: edge-only requests as described in Operation.

## Structure
- Shared package game_pkg holds:
  - the state enum (IDLE/PLAY/WIN/LOSE);
  - MAX_ENEMY, MAX_ENEMY_BULLET, MAX_PLAYER_BULLET;
  - the slot index width;
  - default TICK_DIV/PHASE_LEN/COOLDOWN.
- One sub-module, rr_slot_picker, is combinational:
  - inputs: free bitmap and pointer;
  - outputs: found flag and index;
  - it is reused later for enemy slot allocation.

## Test plan
Bench parameters: TICK_DIV=4, PHASE_LEN=4, COOLDOWN=2.
- **Reset/start:** i_Rst low then high with i_Start held 0 → o_State=0 and no o_Tick for 50 cycles. Then pulse i_Start → o_State=1, and o_Tick every 4th cycle.
- **Volleys:** in PLAY with i_EnemyAlive=15'h7FFF → FireA on tick 4, FireB on tick 8, FireA on tick 12, with o_Phase=1,2,3. If i_EnemyAlive reaches 0 before tick 8 (no other change), the FSM moves to WIN on the next cycle, so no volley is ever emitted with i_EnemyAlive==0.
- **Player arbitration:** i_PlayerSlotFree=16'hFFF0, pointer 0, press fire → o_PlayerFire with slot 4. A second press right away → shot delayed until cooldown expires (3rd tick after), slot 5.
- **No free slot:** i_PlayerSlotFree=0, press, then set bit 2 two ticks later → fire on the next tick with slot 2; no additional shots.
- **End conditions:** i_PlayerAlive=0 and i_EnemyAlive=0 in the same cycle → o_State=LOSE next cycle and all pulses 0. A start edge → IDLE; a second start edge → PLAY with o_Phase=0.
- **Autofire** (GAME_AUTOFIRE_EN defined): hold fire with all slots free → o_PlayerFire every 3 ticks, slots 0,1,2,…

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the shooter game datapath: game-state
// encoding, entity counts, slot index width and default timing parameters.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } game_state_e;

    localparam int MAX_ENEMY         = 15;
    localparam int MAX_ENEMY_BULLET  = 2 * MAX_ENEMY;
    localparam int MAX_PLAYER_BULLET = 16;
    localparam int PSLOT_W           = $clog2(MAX_PLAYER_BULLET);

    localparam int DEF_TICK_DIV  = 416667;
    localparam int DEF_PHASE_LEN = 128;
    localparam int DEF_COOLDOWN  = 11;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Control/status bundle between the game sequencer (slave side) and the
// surrounding datapath or bench (master side).
interface game_flow_ctrl_if;
    import game_pkg::*;

    logic                         i_Start;
    logic                         i_fPlayerShoot;
    logic [MAX_ENEMY-1:0]         i_EnemyAlive;
    logic                         i_PlayerAlive;
    logic [MAX_PLAYER_BULLET-1:0] i_PlayerSlotFree;

    logic [1:0]                   o_State;
    logic                         o_Tick;
    logic [1:0]                   o_Phase;
    logic                         o_EnemyFireA;
    logic                         o_EnemyFireB;
    logic                         o_PlayerFire;
    logic [PSLOT_W-1:0]           o_PlayerSlot;

    modport master (
        output i_Start, i_fPlayerShoot, i_EnemyAlive, i_PlayerAlive, i_PlayerSlotFree,
        input  o_State, o_Tick, o_Phase, o_EnemyFireA, o_EnemyFireB, o_PlayerFire, o_PlayerSlot
    );

    modport slave (
        input  i_Start, i_fPlayerShoot, i_EnemyAlive, i_PlayerAlive, i_PlayerSlotFree,
        output o_State, o_Tick, o_Phase, o_EnemyFireA, o_EnemyFireB, o_PlayerFire, o_PlayerSlot
    );

endinterface

// File: rtl/rr_slot_picker.sv
// Combinational round-robin picker: first set bit of a free bitmap searching
// upward from a pointer with wrap. N must be a power of two.
module rr_slot_picker
    import game_pkg::*;
#(
    parameter int N = MAX_PLAYER_BULLET,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] free_map,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // Index arithmetic wraps naturally because N fills the W-bit range.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + W'(i);
            if (!found && free_map[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: movement tick, game-state FSM, enemy volley schedule and
// player shot arbitration. Define GAME_AUTOFIRE_EN for held-button autofire.
//
// state | meaning
// IDLE  | waiting for start edge
// PLAY  | game running, tick/volley/shot logic active
// WIN   | all enemies dead, waiting for start edge
// LOSE  | player dead, waiting for start edge
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int PHASE_LEN = DEF_PHASE_LEN,
    parameter int COOLDOWN  = DEF_COOLDOWN
) (
    input logic             i_Clk,
    input logic             i_Rst,
    game_flow_ctrl_if.slave bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [6:0]    PHASE_LAST = 7'(PHASE_LEN - 1);
    localparam logic [CW-1:0] COOL_LOAD  = CW'(COOLDOWN);

    game_state_e        state_q, state_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [6:0]         phase_cnt_q, phase_cnt_d;
    logic [1:0]         phase_q, phase_d;
    logic               volley_q, volley_d;
    logic [CW-1:0]      cooldown_q, cooldown_d;
    logic               pending_q, pending_d;
    logic [PSLOT_W-1:0] ptr_q, ptr_d;
    logic               start_prev_q, start_prev_d;
    logic               shoot_prev_q, shoot_prev_d;
    logic               tick_q, tick_d;
    logic               fire_a_q, fire_a_d;
    logic               fire_b_q, fire_b_d;
    logic               pfire_q, pfire_d;
    logic [PSLOT_W-1:0] pslot_q, pslot_d;

    logic               start_edge, shoot_edge, tick_now, req;
    logic               slot_found;
    logic [PSLOT_W-1:0] slot_idx;

    rr_slot_picker #(.N(MAX_PLAYER_BULLET), .W(PSLOT_W)) u_pick (
        .free_map (bus.i_PlayerSlotFree),
        .ptr      (ptr_q),
        .found    (slot_found),
        .idx      (slot_idx)
    );

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        phase_cnt_d  = phase_cnt_q;
        phase_d      = phase_q;
        volley_d     = volley_q;
        cooldown_d   = cooldown_q;
        pending_d    = pending_q;
        ptr_d        = ptr_q;
        start_prev_d = bus.i_Start;
        shoot_prev_d = bus.i_fPlayerShoot;
        tick_d       = 1'b0;
        fire_a_d     = 1'b0;
        fire_b_d     = 1'b0;
        pfire_d      = 1'b0;
        pslot_d      = '0;
        start_edge   = bus.i_Start & ~start_prev_q;
        shoot_edge   = bus.i_fPlayerShoot & ~shoot_prev_q;
        tick_now     = 1'b0;
        req          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d     = ST_PLAY;
                    tick_cnt_d  = '0;
                    phase_cnt_d = '0;
                    phase_d     = '0;
                    volley_d    = 1'b0;
                    cooldown_d  = '0;
                    pending_d   = 1'b0;
                    ptr_d       = '0;
                end
            end
            ST_PLAY: begin
                // Leaving PLAY suppresses every pulse of this cycle.
                if (!bus.i_PlayerAlive) begin
                    state_d = ST_LOSE;
                end else if (bus.i_EnemyAlive == '0) begin
                    state_d = ST_WIN;
                end else begin
                    tick_now   = (tick_cnt_q == TICK_LAST);
                    tick_cnt_d = tick_now ? '0 : tick_cnt_q + 1'b1;
                    req        = pending_q | shoot_edge;
`ifdef GAME_AUTOFIRE_EN
                    req        = req | (tick_now & bus.i_fPlayerShoot);
`endif
                    pending_d  = req;
                    if (tick_now) begin
                        tick_d = 1'b1;
                        if (phase_cnt_q == PHASE_LAST) begin
                            phase_cnt_d = '0;
                            phase_d     = phase_q + 1'b1;
                            volley_d    = ~volley_q;
                            fire_a_d    = ~volley_q & (|bus.i_EnemyAlive);
                            fire_b_d    = volley_q & (|bus.i_EnemyAlive);
                        end else begin
                            phase_cnt_d = phase_cnt_q + 1'b1;
                        end
                        if (req && cooldown_q == '0 && slot_found) begin
                            pfire_d    = 1'b1;
                            pslot_d    = slot_idx;
                            ptr_d      = slot_idx + 1'b1;
                            pending_d  = 1'b0;
                            cooldown_d = COOL_LOAD;
                        end else if (cooldown_q != '0) begin
                            cooldown_d = cooldown_q - 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (start_edge) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            phase_cnt_q  <= '0;
            phase_q      <= '0;
            volley_q     <= 1'b0;
            cooldown_q   <= '0;
            pending_q    <= 1'b0;
            ptr_q        <= '0;
            start_prev_q <= 1'b0;
            shoot_prev_q <= 1'b0;
            tick_q       <= 1'b0;
            fire_a_q     <= 1'b0;
            fire_b_q     <= 1'b0;
            pfire_q      <= 1'b0;
            pslot_q      <= '0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            phase_cnt_q  <= phase_cnt_d;
            phase_q      <= phase_d;
            volley_q     <= volley_d;
            cooldown_q   <= cooldown_d;
            pending_q    <= pending_d;
            ptr_q        <= ptr_d;
            start_prev_q <= start_prev_d;
            shoot_prev_q <= shoot_prev_d;
            tick_q       <= tick_d;
            fire_a_q     <= fire_a_d;
            fire_b_q     <= fire_b_d;
            pfire_q      <= pfire_d;
            pslot_q      <= pslot_d;
        end
    end

    assign bus.o_State      = state_q;
    assign bus.o_Tick       = tick_q;
    assign bus.o_Phase      = phase_q;
    assign bus.o_EnemyFireA = fire_a_q;
    assign bus.o_EnemyFireB = fire_b_q;
    assign bus.o_PlayerFire = pfire_q;
    assign bus.o_PlayerSlot = pslot_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus random fire/slot traffic,
// all checked cycle by cycle against a tick-counting behavioural model.
module tb_game_flow_ctrl;
    import game_pkg::*;

    localparam int TDIV = 4;
    localparam int PLEN = 4;
    localparam int CD   = 2;
`ifdef GAME_AUTOFIRE_EN
    localparam bit AUTOFIRE = 1'b1;
`else
    localparam bit AUTOFIRE = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(.TICK_DIV(TDIV), .PHASE_LEN(PLEN), .COOLDOWN(CD)) dut (
        .i_Clk (clk),
        .i_Rst (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model state: counts cycles and ticks since entering PLAY.
    int m_state, m_cycles, m_ticks, m_next_ok, m_ptr, m_phase;
    bit m_pending, m_prev_start, m_prev_shoot;
    bit e_tick, e_fa, e_fb, e_pf;
    int e_slot;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_cycles = 0; m_ticks = 0; m_next_ok = 0; m_ptr = 0; m_phase = 0;
        m_pending = 0; m_prev_start = 0; m_prev_shoot = 0;
        e_tick = 0; e_fa = 0; e_fb = 0; e_pf = 0; e_slot = 0;
    endfunction

    function automatic void model_cycle();
        bit start_edge, shoot_edge, tick, req, found;
        int slot;
        start_edge = bus.i_Start && !m_prev_start;
        shoot_edge = bus.i_fPlayerShoot && !m_prev_shoot;
        m_prev_start = bus.i_Start;
        m_prev_shoot = bus.i_fPlayerShoot;
        e_tick = 0; e_fa = 0; e_fb = 0; e_pf = 0; e_slot = 0;
        if (m_state == 0) begin
            if (start_edge) begin
                m_state = 1; m_cycles = 0; m_ticks = 0; m_next_ok = 0;
                m_ptr = 0; m_phase = 0; m_pending = 0;
            end
        end else if (m_state == 1) begin
            if (!bus.i_PlayerAlive) m_state = 3;
            else if (bus.i_EnemyAlive == 0) m_state = 2;
            else begin
                m_cycles++;
                tick = (m_cycles % TDIV) == 0;
                req = m_pending || shoot_edge || (AUTOFIRE && tick && bus.i_fPlayerShoot);
                if (tick) begin
                    e_tick = 1;
                    m_ticks++;
                    if (m_ticks % PLEN == 0) begin
                        m_phase = (m_ticks / PLEN) % 4;
                        if (((m_ticks / PLEN) % 2) == 1) e_fa = 1;
                        else e_fb = 1;
                    end
                    found = 0; slot = 0;
                    for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
                        int s;
                        s = (m_ptr + k) % MAX_PLAYER_BULLET;
                        if (!found && bus.i_PlayerSlotFree[s]) begin
                            found = 1; slot = s;
                        end
                    end
                    if (req && m_ticks >= m_next_ok && found) begin
                        e_pf = 1; e_slot = slot;
                        m_ptr = (slot + 1) % MAX_PLAYER_BULLET;
                        m_next_ok = m_ticks + CD + 1;
                        req = 0;
                    end
                end
                m_pending = req;
            end
        end else begin
            if (start_edge) m_state = 0;
        end
    endfunction

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        chk("state",  int'(bus.o_State),      m_state);
        chk("tick",   int'(bus.o_Tick),       int'(e_tick));
        chk("phase",  int'(bus.o_Phase),      m_phase);
        chk("fire_a", int'(bus.o_EnemyFireA), int'(e_fa));
        chk("fire_b", int'(bus.o_EnemyFireB), int'(e_fb));
        chk("pfire",  int'(bus.o_PlayerFire), int'(e_pf));
        chk("pslot",  int'(bus.o_PlayerSlot), e_slot);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_start();
        bus.i_Start = 1'b1; step();
        bus.i_Start = 1'b0; step();
    endtask

    task automatic press();
        bus.i_fPlayerShoot = 1'b1; step();
        bus.i_fPlayerShoot = 1'b0;
    endtask

    task automatic run_until_pfire(input int budget, output int slot);
        int got;
        got = 0; slot = -1;
        for (int n = 0; n < budget; n++) begin
            step();
            if (bus.o_PlayerFire) begin
                got = 1; slot = int'(bus.o_PlayerSlot);
                break;
            end
        end
        chk("pfire_seen", got, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"},  int'(bus.o_State),      0);
        chk({tag, "_tick"},   int'(bus.o_Tick),       0);
        chk({tag, "_phase"},  int'(bus.o_Phase),      0);
        chk({tag, "_fire_a"}, int'(bus.o_EnemyFireA), 0);
        chk({tag, "_fire_b"}, int'(bus.o_EnemyFireB), 0);
        chk({tag, "_pfire"},  int'(bus.o_PlayerFire), 0);
        chk({tag, "_pslot"},  int'(bus.o_PlayerSlot), 0);
    endtask

    initial begin
        int slot;
        bus.i_Start = 0; bus.i_fPlayerShoot = 0;
        bus.i_EnemyAlive = 15'h7FFF; bus.i_PlayerAlive = 1;
        bus.i_PlayerSlotFree = 16'hFFF0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst_n = 1'b1;

        // Idle with start low: nothing moves.
        steps(50);

        // Start, then player arbitration from pointer 0.
        pulse_start();
        chk("play_after_start", int'(bus.o_State), 1);
        press();
        run_until_pfire(20, slot);
        chk("first_slot", slot, 4);
        press();
        run_until_pfire(30, slot);
        chk("second_slot", slot, 5);

        // No free slot: request stays pending until bit 2 frees up.
        steps(20);
        bus.i_PlayerSlotFree = 16'h0000;
        press();
        steps(2 * TDIV);
        bus.i_PlayerSlotFree = 16'h0004;
        run_until_pfire(2 * TDIV, slot);
        chk("retry_slot", slot, 2);
        steps(30);

        // Enemies cleared -> WIN; two start edges back to a fresh PLAY.
        bus.i_EnemyAlive = 15'h0000; step();
        chk("win_state", int'(bus.o_State), 2);
        bus.i_EnemyAlive = 15'h7FFF;
        steps(3);
        pulse_start();
        pulse_start();
        chk("replay_phase", int'(bus.o_Phase), 0);
        bus.i_PlayerSlotFree = 16'hFFFF;

        // Random traffic during PLAY.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) bus.i_fPlayerShoot = ~bus.i_fPlayerShoot;
            if ($urandom_range(0, 15) == 0) bus.i_PlayerSlotFree = 16'($urandom & $urandom);
            if ($urandom_range(0, 30) == 0) bus.i_EnemyAlive = 15'($urandom_range(1, 32767));
            if ($urandom_range(0, 20) == 0) bus.i_Start = ~bus.i_Start;
            step();
        end
        bus.i_Start = 0; bus.i_fPlayerShoot = 0;
        steps(2);

        // Both end conditions together: LOSE takes priority.
        bus.i_PlayerAlive = 0; bus.i_EnemyAlive = 15'h0000; step();
        chk("lose_state", int'(bus.o_State), 3);
        bus.i_PlayerAlive = 1; bus.i_EnemyAlive = 15'h7FFF;
        steps(2);
        pulse_start();
        chk("lose_to_idle", int'(bus.o_State), 0);
        pulse_start();
        steps(12);

        // Asynchronous reset mid-game.
        bus.i_fPlayerShoot = 0;
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        steps(3);

        // Held fire button with all slots free.
        pulse_start();
        bus.i_PlayerSlotFree = 16'hFFFF;
        bus.i_fPlayerShoot = 1;
        steps(20 * TDIV);
        bus.i_fPlayerShoot = 0;
        steps(10);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
